// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the dual-port data memory: clear-sequencer
// states, default geometry and the CPU address legality check.
package data_memory_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 64;
    localparam int NBYTES     = DEF_DATA_W / 8;

    // A byte address is legal when word-aligned and its word index is inside the array.
    function automatic logic word_legal(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
    endfunction

endpackage

// File: rtl/dm_clear_seq.sv
// Clear sequencer: walks every word index once after reset or on request,
// asserting busy for exactly DEPTH cycles.
module dm_clear_seq
    import data_memory_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_idx = cnt_q;

endmodule

// File: rtl/data_memory_dp.sv
// Dual-port data memory: CPU load/store port with byte enables and fault
// reporting, plus a registered read-only port with a req/valid handshake.
module data_memory_dp
    import data_memory_pkg::*;
#(
    parameter int DATA_W  = 8 * NBYTES,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = 32,
    parameter int VADDR_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WE,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [ADDR_W-1:0]   a,
    input  logic [DATA_W-1:0]   WD,
    output logic [DATA_W-1:0]   Rd,
    output logic                err,
    input  logic                clr_req,
    output logic                busy,
    input  logic                rv_req,
    input  logic [VADDR_W-1:0]  rv_addr,
    output logic                rv_ready,
    output logic                rv_valid,
    output logic [DATA_W-1:0]   Rdv
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               legal;
    logic [VADDR_W-1:0] idx;
    logic               cpu_we;
    logic               rv_accept;
    logic               clr_we;
    logic [VADDR_W-1:0] clr_idx;

    dm_clear_seq #(
        .DEPTH (DEPTH),
        .IDX_W (VADDR_W)
    ) u_clear_seq (
        .CLK     (CLK),
        .RST     (RST),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign legal     = word_legal(64'(a), DEPTH);
    assign idx       = a[VADDR_W+1:2];
    assign cpu_we    = WE && legal && !busy;
    assign rv_ready  = !busy;
    assign rv_accept = rv_req && rv_ready;

    // Loads see the pre-edge contents, so a same-cycle store returns old data.
    assign Rd = (legal && !busy) ? mem[idx] : '0;

    // NOTE: the array has no reset; the clear sequencer zeroes it after reset instead.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (cpu_we) begin
            for (int i = 0; i < NB; i++) begin
                if (BE[i]) mem[idx][8*i +: 8] <= WD[8*i +: 8];
            end
        end
    end

    // Loads are recognised by a non-zero BE with WE low; faults while busy are not reported.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err      <= 1'b0;
            rv_valid <= 1'b0;
            Rdv      <= '0;
        end else begin
            err      <= !busy && !legal && (WE || (BE != '0));
            rv_valid <= rv_accept;
            if (rv_accept) Rdv <= mem[rv_addr];
        end
    end

endmodule

// File: tb/tb_data_memory_dp.sv
// Self-checking bench for data_memory_dp: vector table for the CPU port,
// scoreboard queue for the read port, hand sequences for clear and reset.
module tb_data_memory_dp;
    import data_memory_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 32;
    localparam int VW    = 6;

    logic              CLK;
    logic              RST;
    logic              WE;
    logic [NBYTES-1:0] BE;
    logic [AW-1:0]     a;
    logic [DW-1:0]     WD;
    logic [DW-1:0]     Rd;
    logic              err;
    logic              clr_req;
    logic              busy;
    logic              rv_req;
    logic [VW-1:0]     rv_addr;
    logic              rv_ready;
    logic              rv_valid;
    logic [DW-1:0]     Rdv;

    data_memory_dp #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .ADDR_W  (AW),
        .VADDR_W (VW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WE       (WE),
        .BE       (BE),
        .a        (a),
        .WD       (WD),
        .Rd       (Rd),
        .err      (err),
        .clr_req  (clr_req),
        .busy     (busy),
        .rv_req   (rv_req),
        .rv_addr  (rv_addr),
        .rv_ready (rv_ready),
        .rv_valid (rv_valid),
        .Rdv      (Rdv)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic              we;
        logic [NBYTES-1:0] be;
        logic [AW-1:0]     addr;
        logic [DW-1:0]     wd;
        logic [DW-1:0]     exp_rd;
        logic              exp_err;
    } vec_t;

    vec_t          vecs [14];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] sb_exp;
    int            total;
    int            bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic model_write(input logic [AW-1:0] addr, input logic [NBYTES-1:0] be,
                               input logic [DW-1:0] wd);
        if (addr[1:0] == 2'b00 && (addr >> 2) < DEPTH) begin
            for (int i = 0; i < NBYTES; i++)
                if (be[i]) model[addr >> 2][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        WE = 1'b1; BE = '1; a = addr; WD = wd;
        model_write(addr, '1, wd);
        tick();
        WE = 1'b0; BE = '0;
    endtask

    task automatic rv_read(input int idx);
        rv_req  = 1'b1;
        rv_addr = VW'(idx);
        sb_q.push_back(model[idx]);
        tick();
        rv_req = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'd64);
    endtask

    // Read-port scoreboard: every valid pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (rv_valid) begin
            check("rv_queue_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                check("rv_data", Rdv, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0; bad = 0;
        RST = 1'b1; WE = 1'b0; BE = '0; a = '0; WD = '0;
        clr_req = 1'b0; rv_req = 1'b0; rv_addr = '0;

        vecs[0]  = '{1'b1, 4'hF, 32'h10,  32'hAABBCCDD, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 4'h5, 32'h10,  32'h11223344, 32'hAABBCCDD, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 32'h10,  32'h00000000, 32'hAA22CC44, 1'b0};
        vecs[3]  = '{1'b1, 4'hF, 32'h13,  32'hDEADBEEF, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b0, 4'hF, 32'h10,  32'h00000000, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 4'hF, 32'h100, 32'h00000000, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 4'h0, 32'h20,  32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 4'hF, 32'h20,  32'h00000000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 4'h8, 32'hFC,  32'h12345678, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 4'hF, 32'hFC,  32'h00000000, 32'h12000000, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 32'h101, 32'h00000000, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 4'hF, 32'h0,   32'h00000000, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 4'hF, 32'h1FC, 32'h00000000, 32'h00000000, 1'b1};

        // Reset then idle
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(rv_ready), 32'd0);
        check("rst_valid", 32'(rv_valid), 32'd0);
        check("rst_rdv", Rdv, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        RST = 1'b0;
        wait_clear("reset_clear_len");
        model_clear();
        rv_read(0);
        rv_read(31);
        rv_read(63);
        tick();

        // CPU port vector table
        for (int i = 0; i < 14; i++) begin
            WE = vecs[i].we; BE = vecs[i].be; a = vecs[i].addr; WD = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_rd", i), Rd, vecs[i].exp_rd);
            if (vecs[i].we) model_write(vecs[i].addr, vecs[i].be, vecs[i].wd);
            tick();
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        end
        WE = 1'b0; BE = '0;
        tick();
        check("err_cleared", 32'(err), 32'd0);

        // Read-port collision: read-before-write on the same word
        cpu_write(32'h14, 32'h1);
        WE = 1'b1; BE = '1; a = 32'h14; WD = 32'h2;
        rv_req = 1'b1; rv_addr = VW'(5);
        sb_q.push_back(model[5]);
        model_write(32'h14, '1, 32'h2);
        tick();
        WE = 1'b0; BE = '0; rv_req = 1'b0;
        check("coll_valid", 32'(rv_valid), 32'd1);
        rv_read(5);
        tick();
        check("valid_pulse_end", 32'(rv_valid), 32'd0);
        check("rdv_hold", Rdv, 32'h2);

        // clr_req mid-traffic, with clr_req held (must not restart) and a pending read
        for (int w = 0; w < 4; w++) cpu_write(AW'(4 * w), 32'h100 + 32'(w));
        a = 32'h8; BE = '1;
        #1;
        check("filled_word2", Rd, 32'h102);
        clr_req = 1'b1;
        tick();
        WE = 1'b1; a = 32'h8; WD = 32'hFFFFFFFF; BE = '1;
        rv_req = 1'b1; rv_addr = VW'(2);
        model_clear();
        sb_q.push_back(model[2]);
        n = 0;
        while (busy && n < 200) begin
            if (n % 16 == 0) begin
                check("busy_ready_low", 32'(rv_ready), 32'd0);
                check("busy_rd_zero", Rd, 32'd0);
            end
            tick();
            check("busy_no_err", 32'(err), 32'd0);
            n++;
        end
        check("clr_req_len", 32'(n), 32'd64);
        WE = 1'b0; BE = '0; clr_req = 1'b0;
        tick();
        rv_req = 1'b0;
        check("held_req_valid", 32'(rv_valid), 32'd1);
        a = 32'h8; BE = '1;
        #1;
        check("busy_write_dropped", Rd, 32'd0);
        BE = '0;
        for (int w = 0; w < 4; w++) rv_read(w);
        tick();

        // Reset mid-clear restarts the full sequence
        cpu_write(32'h40, 32'h5A5A5A5A);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (20) tick();
        check("mid_clear_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rv_valid), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        wait_clear("rst_mid_clear_len");
        model_clear();
        rv_read(16);
        rv_read(63);
        tick();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_dp.md
Name: data_memory_dp

Overview:
- Parametrised successor to the single-port data memory.
- Provides a CPU load/store port with byte-enable writes and address checking.
- Provides a second read-only port (display/debug) with a req/valid handshake.
- Contains a clear sequencer that zeroes the array after reset or on request.
- Sits between the datapath ALU-result/store-data bus and the writeback mux; the second port feeds the video/debug reader.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 64: number of words; must be a power of two, at least 2.
- ADDR_W, 32: CPU byte-address width.
- VADDR_W, $clog2(DEPTH): read-port word-index width.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- RST, input, 1: asynchronous, active-high reset.
- WE, input, 1: CPU write enable.
- BE, input, DATA_W/8: byte enables; bit i covers WD[8i+7:8i].
- a, input, ADDR_W: CPU byte address.
- WD, input, DATA_W: CPU write data.
- Rd, output, DATA_W: CPU read data (combinational).
- err, output, 1: registered access-fault pulse.
- clr_req, input, 1: start a full clear.
- busy, output, 1: clear in progress.
- rv_req, input, 1: read-port request.
- rv_addr, input, VADDR_W: read-port word index.
- rv_ready, output, 1: read port can accept a request.
- rv_valid, output, 1: Rdv holds new data (one-cycle pulse).
- Rdv, output, DATA_W: read-port data (registered).

Behaviour:
- Word index is a[ADDR_W-1:2]. An access is legal when a[1:0]==0 and the word index is below DEPTH.
- Reset (RST=1, asynchronous):
  - busy=1, rv_valid=0, Rdv=0, err=0, clear counter=0, FSM=CLEAR.
  - Array contents are don't-care; the clear sequence zeroes them.
- FSM states:
  - CLEAR: write 0 to word[cnt] each cycle; cnt increments. When cnt==DEPTH-1, write it and go to READY. Takes exactly DEPTH cycles; busy=1 throughout.
  - READY: busy=0. clr_req=1 -> CLEAR with cnt=0 on the next edge.
  - clr_req while already in CLEAR is ignored; it does not restart the sequence.
- RST asserted mid-clear restarts the sequence from 0.
- CPU read:
  - Rd = word[index] combinationally when legal and busy=0.
  - Rd = 0 when the access is illegal or busy=1.
  - A same-cycle write to the same word returns the old data; the write lands at the edge.
- CPU write:
  - On the CLK edge when WE && legal && !busy, only the bytes with BE[i]=1 are updated.
  - BE=0 is a no-op with no error.
- Error reporting:
  - err=1 for one cycle after an edge where (WE || the address is being driven for a load) meets an illegal access. The datapath qualifies loads with WE=0 and BE≠0.
  - An illegal write never modifies the array.
  - A WE during busy is dropped silently with err=0.
- Read port:
  - rv_ready = !busy.
  - A request is accepted on an edge with rv_req && rv_ready.
  - The next cycle gives rv_valid=1 and Rdv = word[rv_addr] as of before that edge's CPU write (read-before-write on collision).
  - Rdv holds its value until the next accepted request.
  - Back-to-back requests give back-to-back valids.
  - Requests while busy are not accepted; the requester holds rv_req.
- rv_addr needs no range check because VADDR_W indexes exactly DEPTH words.

Decomposition:
- Package data_memory_pkg holds:
  - the state enum {CLEAR, READY};
  - function word_legal(addr, depth);
  - localparam NBYTES = DATA_W/8.
- One sub-module, dm_clear_seq: the FSM plus counter. It outputs busy, clr_we and clr_idx; the top module muxes the write path.
- The array and both ports stay in the top module.

Test Plan:
- Reset then idle:
  - RST high 3 cycles, then low.
  - busy=1 for exactly 64 cycles, then 0.
  - Read-port reads of indices 0, 31 and 63 all give Rdv=0.
- Byte-enable write:
  - a=0x10, WD=0xAABBCCDD, BE=4'b1111; then WD=0x11223344, BE=4'b0101.
  - Rd at a=0x10 = 0xAA22CC44.
- Illegal accesses:
  - WE with a=0x13 gives err=1 for one cycle and memory is unchanged.
  - WE with a=0x100 (index 64) gives err=1; Rd=0 while that address is held.
- Read-port collision:
  - Word 5 = 0x1. Same cycle: CPU writes 0x2 to a=0x14 and rv_req with rv_addr=5.
  - Next cycle: rv_valid=1, Rdv=0x1.
  - A following request returns 0x2.
- clr_req mid-traffic:
  - Fill words 0-3. Pulse clr_req.
  - busy=1 for 64 cycles; WE during busy is dropped; rv_ready=0; a held rv_req is accepted on the first READY cycle and returns 0.
- Reset mid-clear:
  - Assert RST at clear cycle 20.
  - After release, busy stays high for a full 64 cycles, not 44.
